// File: rtl/simple_ram_pkg.sv
// Shared types and helpers for the SimpleCPU RAM responder.
// SIMPLE_RAM_PARITY_EN adds a stored even-parity bit per word.
package simple_ram_pkg;

    localparam int WORD_W = 32;

`ifdef SIMPLE_RAM_PARITY_EN
    localparam int MEM_W = WORD_W + 1;
`else
    localparam int MEM_W = WORD_W;
`endif

    typedef logic [1:0] state_t;

    localparam state_t RUN   = 2'd0;
    localparam state_t LOAD  = 2'd1;
    localparam state_t DRAIN = 2'd2;

    function automatic logic parity(input logic [WORD_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/simple_ram_if.sv
// CPU bus and image-loader port of the RAM responder.
// master = CPU/boot agent side, slave = responder side.
interface simple_ram_if
    import simple_ram_pkg::*;
#(
    parameter int SIZE = 14
);
    logic              wrEn;
    logic [SIZE-1:0]   addr_toRAM;
    logic [WORD_W-1:0] data_toRAM;
    logic [WORD_W-1:0] data_fromRAM;
    logic              parity_err;

    logic              ld_valid;
    logic              ld_ready;
    logic [SIZE-1:0]   ld_addr;
    logic [WORD_W-1:0] ld_data;
    logic              ld_last;
    logic              busy;
    logic [SIZE:0]     ld_count;

    modport master (
        output wrEn, addr_toRAM, data_toRAM,
        output ld_valid, ld_addr, ld_data, ld_last,
        input  data_fromRAM, parity_err, ld_ready, busy, ld_count
    );

    modport slave (
        input  wrEn, addr_toRAM, data_toRAM,
        input  ld_valid, ld_addr, ld_data, ld_last,
        output data_fromRAM, parity_err, ld_ready, busy, ld_count
    );

endinterface

// File: rtl/simple_ram_array.sv
// Single-write-port, read-first word store; contents are never reset.
// Word width follows MEM_W (one extra parity bit under SIMPLE_RAM_PARITY_EN).
module simple_ram_array
    import simple_ram_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IW-1:0]    waddr,
    input  logic [MEM_W-1:0] wdata,
    input  logic [IW-1:0]    raddr,
    output logic [MEM_W-1:0] rdata
);

    logic [MEM_W-1:0] mem [DEPTH];

    // read samples the old word when the same address is written this edge
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/simple_ram_responder.sv
// RAM responder for SimpleCPU: 1-cycle registered reads plus an image loader.
// Optional read parity checking under SIMPLE_RAM_PARITY_EN.
//
// state | meaning
// RUN   | CPU owns the array; ld_valid requests a load
// LOAD  | loader beats accepted 1/cycle, CPU port ignored
// DRAIN | one idle cycle after the last beat, then back to RUN
module simple_ram_responder
    import simple_ram_pkg::*;
#(
    parameter int SIZE  = 14,
    parameter int DEPTH = 2**SIZE
) (
    input  logic       clk,
    input  logic       rst,
    simple_ram_if.slave bus
);

    localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SIZE:0] DEPTH_L  = (SIZE+1)'(DEPTH);
    localparam logic [SIZE:0] CNT_MAX  = {1'b1, {SIZE{1'b0}}};

    state_t            state;
    state_t            state_n;
    logic              cpu_in_range;
    logic              ld_in_range;
    logic              ld_fire;
    logic              rd_en_q;
    logic [SIZE:0]     ld_count_q;

    logic              arr_we;
    logic [IW-1:0]     arr_waddr;
    logic [WORD_W-1:0] arr_wword;
    logic [MEM_W-1:0]  arr_wdata;
    logic [MEM_W-1:0]  arr_rdata;

    assign cpu_in_range = {1'b0, bus.addr_toRAM} < DEPTH_L;
    assign ld_in_range  = {1'b0, bus.ld_addr} < DEPTH_L;
    assign bus.ld_ready = (state == LOAD);
    assign bus.busy     = (state != RUN);
    assign ld_fire      = bus.ld_valid && bus.ld_ready;

    always_comb begin
        state_n = state;
        case (state)
            RUN:     if (bus.ld_valid) state_n = LOAD;
            LOAD:    if (ld_fire && bus.ld_last) state_n = DRAIN;
            DRAIN:   state_n = RUN;
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    // ld_count restarts on the RUN->LOAD edge and saturates at 2**SIZE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_count_q <= '0;
        end else if (state == RUN && bus.ld_valid) begin
            ld_count_q <= '0;
        end else if (ld_fire && ld_count_q != CNT_MAX) begin
            ld_count_q <= ld_count_q + 1'b1;
        end
    end

    assign bus.ld_count = ld_count_q;

    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = bus.addr_toRAM[IW-1:0];
        arr_wword = bus.data_toRAM;
        if (state == RUN) begin
            arr_we = bus.wrEn && cpu_in_range;
        end else begin
            arr_we    = ld_fire && ld_in_range;
            arr_waddr = bus.ld_addr[IW-1:0];
            arr_wword = bus.ld_data;
        end
    end

`ifdef SIMPLE_RAM_PARITY_EN
    assign arr_wdata = {parity(arr_wword), arr_wword};
`else
    assign arr_wdata = arr_wword;
`endif

    simple_ram_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .raddr (bus.addr_toRAM[IW-1:0]),
        .rdata (arr_rdata)
    );

    // array output is only meaningful for an in-range read taken in RUN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en_q <= 1'b0;
        end else begin
            rd_en_q <= (state == RUN) && cpu_in_range;
        end
    end

    assign bus.data_fromRAM = rd_en_q ? arr_rdata[WORD_W-1:0] : '0;

`ifdef SIMPLE_RAM_PARITY_EN
    assign bus.parity_err = rd_en_q &&
                            (arr_rdata[WORD_W] ^ parity(arr_rdata[WORD_W-1:0]));
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule
